pnode_result_arbiter: RTL
=========================

Name: pnode_result_arbiter

Overview:
- Round-robin arbiter that merges the per-match-node result streams into one tagged output stream.
- Inputs are NCOUNT result ports, each a 10-bit tag with a valid/ack handshake. The output is one Avalon-ST-style stream (data/channel/valid/ready) that feeds the return path toward the MAC-side packer.
- Contains a single-entry output register, a rotating priority pointer and two performance counters.

Parameters:
- NCOUNT, 8, number of requesting match nodes; legal range 1..16, need not be a power of 2.
- DW, 10, width of each result tag.
- CW, 4, width of out_channel; must satisfy 2^CW >= NCOUNT.

Ports:
- clock  input  1  sole clock; all logic on the rising edge.
- sclr  input  1  synchronous reset, active-high.
- req_data  input  NCOUNT*DW  result tags; node i occupies bits [i*DW +: DW].
- req_valid  input  NCOUNT  node i has a result pending; held until acked.
- req_ack  output  NCOUNT  one-cycle consume pulse per node; combinational in the grant cycle.
- out_data  output  DW  granted tag.
- out_channel  output  CW  index of the node that produced out_data.
- out_valid  output  1  output register holds a valid beat.
- out_ready  input  1  downstream accepts the beat when out_valid && out_ready.
- beat_count  output  32  count of beats delivered downstream; wraps.
- stall_count  output  32  count of cycles with out_valid && !out_ready; wraps.

Behaviour:
- Interface decision: one clock (clock); reset is synchronous and active-high (sclr).
- Reset values while sclr=1:
  - out_valid=0, out_data=0, out_channel=0.
  - req_ack=0 (forced, regardless of requests).
  - beat_count=0, stall_count=0.
  - pointer last_grant=NCOUNT-1, so node 0 has top priority first.
- Slot availability: load_en = !out_valid || out_ready. A full register that drains this cycle may refill in the same cycle, which sustains 1 beat/clock.
- Arbitration, evaluated when load_en && any req_valid && !sclr:
  - Search order starts at (last_grant+1) mod NCOUNT and wraps modulo NCOUNT, including non-power-of-2 values.
  - The first node with req_valid=1 is granted.
- Grant cycle n, for granted node g:
  - req_ack[g]=1 combinationally; all other ack bits are 0; at most one ack bit is high in any cycle.
  - At the edge ending cycle n: out_data <= req_data[g], out_channel <= g, out_valid <= 1, last_grant <= g.
- Latency: req_valid high in cycle n with the slot free gives req_ack in cycle n and out_valid in cycle n+1.
- No grant (load_en=0 or no requests):
  - req_ack=0.
  - If out_valid && out_ready, then out_valid <= 0.
  - Otherwise the register and pointer hold.
  - out_data and out_channel are stable while out_valid && !out_ready.
- Requester contract: a node may hold req_valid high after its ack with new data, for back-to-back results. It will not be re-granted while any other node is valid, because the pointer has moved past it.
- Fairness: with all NCOUNT nodes continuously valid and out_ready=1, grants cycle 0,1,…,NCOUNT-1,0 with no repeats. Worst-case wait is NCOUNT-1 grants.
- NCOUNT=1: pointer stays 0; the block degenerates to a registered pass-through.
- Counters:
  - beat_count increments on each out_valid && out_ready.
  - stall_count increments on each out_valid && !out_ready.
  - Both wrap at 2^32 (0xFFFFFFFF -> 0).
  - Neither increments in a cycle where sclr=1.
- sclr asserted mid-operation: a buffered beat is discarded and never delivered, with no ack replay. Nodes that were not acked keep their results pending and compete normally once sclr deasserts, starting from node 0 priority.
- req_valid deasserting without an ack (node withdraw) is legal: the node simply loses eligibility.

Test Plan:
1. Reset then single request: sclr 1→0; node 3 asserts req_valid with data 0x2A5, out_ready=1 → req_ack[3] high the same cycle; next cycle out_valid=1, out_data=0x2A5, out_channel=3; beat_count=1 one cycle later.
2. All-request fairness: NCOUNT=8, all req_valid=1 with data=i, out_ready=1 for 16 cycles → out_channel sequence 0..7,0..7; exactly one ack per cycle; 16 beats delivered; stall_count=0.
3. Backpressure: out_ready=0 for 5 cycles while nodes 1 and 6 are valid → out_data/out_channel held at node 1's value; no further acks; stall_count=5. Then out_ready=1 → node 6 granted the same cycle node 1's beat drains, back-to-back.
4. Non-power-of-2 wrap: NCOUNT=5, last grant node 4, nodes 0 and 4 valid → node 0 granted; node 4 is served next.
5. Reset mid-stall: out_valid=1 and stalled, node 2 pending and not acked; pulse sclr one cycle → out_valid=0 and counters=0 the following cycle; node 2 acked after release; the discarded beat never appears.
6. Counter wrap: force beat_count to 0xFFFFFFFF via backdoor, deliver one beat → beat_count=0x00000000.

Source files
------------

// File: rtl/pnode_result_arbiter_if.sv
// Result-merge bus: per-node tag/valid/ack requests in, one tagged stream plus perf counters out.
// The slave modport is the arbiter side; the master modport is the requester/sink side.
interface pnode_result_arbiter_if #(
  parameter int NCOUNT = 8,
  parameter int DW     = 10,
  parameter int CW     = 4
);
  logic [NCOUNT*DW-1:0] req_data;
  logic [NCOUNT-1:0]    req_valid;
  logic [NCOUNT-1:0]    req_ack;
  logic [DW-1:0]        out_data;
  logic [CW-1:0]        out_channel;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          beat_count;
  logic [31:0]          stall_count;

  modport slave (
    input  req_data, req_valid, out_ready,
    output req_ack, out_data, out_channel, out_valid, beat_count, stall_count
  );

  modport master (
    output req_data, req_valid, out_ready,
    input  req_ack, out_data, out_channel, out_valid, beat_count, stall_count
  );
endinterface

// File: rtl/pnode_result_arbiter.sv
// Round-robin merge of match-node result tags into one registered, channel-tagged stream.
// The output slot refills in the cycle it drains, so one beat per clock is sustained.
module pnode_result_arbiter #(
  parameter int NCOUNT = 8,
  parameter int DW     = 10,
  parameter int CW     = 4
) (
  input  logic                 clock,
  input  logic                 sclr,
  pnode_result_arbiter_if.slave bus
);
  logic [CW-1:0]     last_grant_q, last_grant_d;
  logic [DW-1:0]     out_data_q, out_data_d;
  logic [CW-1:0]     out_channel_q, out_channel_d;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       beat_count_q, beat_count_d;
  logic [31:0]       stall_count_q, stall_count_d;

  logic              load_en;
  logic              grant_found;
  logic              grant;
  logic [NCOUNT-1:0] grant_oh;
  logic [DW-1:0]     grant_data;
  logic [CW-1:0]     grant_chan;

  assign load_en = !out_valid_q || bus.out_ready;
  assign grant   = load_en && grant_found && !sclr;

  // Two passes give modulo-NCOUNT order from last_grant+1 without a dynamic index.
  always_comb begin
    grant_found = 1'b0;
    grant_oh    = '0;
    grant_data  = '0;
    grant_chan  = '0;
    for (int i = 0; i < NCOUNT; i++) begin
      if (!grant_found && bus.req_valid[i] && (i > int'(last_grant_q))) begin
        grant_found = 1'b1;
        grant_oh[i] = 1'b1;
        grant_data  = bus.req_data[i*DW +: DW];
        grant_chan  = CW'(i);
      end
    end
    for (int i = 0; i < NCOUNT; i++) begin
      if (!grant_found && bus.req_valid[i] && (i <= int'(last_grant_q))) begin
        grant_found = 1'b1;
        grant_oh[i] = 1'b1;
        grant_data  = bus.req_data[i*DW +: DW];
        grant_chan  = CW'(i);
      end
    end
  end

  always_comb begin
    last_grant_d  = last_grant_q;
    out_data_d    = out_data_q;
    out_channel_d = out_channel_q;
    out_valid_d   = out_valid_q;
    if (grant) begin
      out_data_d    = grant_data;
      out_channel_d = grant_chan;
      out_valid_d   = 1'b1;
      last_grant_d  = grant_chan;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d   = 1'b0;
    end
    beat_count_d  = beat_count_q  + {31'd0, out_valid_q &&  bus.out_ready};
    stall_count_d = stall_count_q + {31'd0, out_valid_q && !bus.out_ready};
  end

  always_ff @(posedge clock) begin
    if (sclr) begin
      last_grant_q  <= CW'(NCOUNT - 1);
      out_data_q    <= '0;
      out_channel_q <= '0;
      out_valid_q   <= 1'b0;
      beat_count_q  <= '0;
      stall_count_q <= '0;
    end else begin
      last_grant_q  <= last_grant_d;
      out_data_q    <= out_data_d;
      out_channel_q <= out_channel_d;
      out_valid_q   <= out_valid_d;
      beat_count_q  <= beat_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign bus.req_ack     = grant ? grant_oh : '0;
  assign bus.out_data    = out_data_q;
  assign bus.out_channel = out_channel_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.beat_count  = beat_count_q;
  assign bus.stall_count = stall_count_q;
endmodule
